// File: rtl/stack_ctrl_if.sv
// Memory request/acknowledge port used by the stack sequencer.
// The master holds req, we, addr and wdata until ack is returned.
interface stack_ctrl_if #(
  parameter int unsigned W = 16
);
  logic         req;
  logic         we;
  logic [W-1:0] addr;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata;
  logic         ack;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output ack
  );
endinterface

// File: rtl/stack_ctrl.sv
// Push/pop sequencer for a full-descending stack: one memory access,
// then a single SP load/inc/dec strobe, then a done (or reject) pulse.
module stack_ctrl #(
  parameter int unsigned    W        = 16,
  parameter logic [W-1:0]   STACK_HI = 16'h1000,
  parameter logic [W-1:0]   STACK_LO = 16'h0F00
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         init_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  input  logic [W-1:0] sp_val_i,
  output logic         sp_ld_o,
  output logic         sp_inc_o,
  output logic         sp_dec_o,
  output logic [W-1:0] sp_din_o,
  stack_ctrl_if.master mem
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM,
    S_UPD,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_INIT,
    OP_PUSH,
    OP_POP
  } op_e;

  state_e       state_q, state_d;
  op_e          op_q, op_d;
  logic [W-1:0] addr_q, addr_d;
  logic [W-1:0] wdata_q, wdata_d;
  logic         we_q, we_d;
  logic         err_q, err_d;
  logic [W-1:0] dout_q, dout_d;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      op_q    <= OP_INIT;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    err_d   = err_q;
    dout_d  = dout_q;
    unique case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        // overlapping strobes resolve as init > push > pop
        priority case (1'b1)
          init_i: begin
            op_d    = OP_INIT;
            state_d = S_UPD;
          end
          push_i: begin
            if (sp_val_i == STACK_LO) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              op_d    = OP_PUSH;
              addr_d  = sp_val_i - W'(1);
              wdata_d = din_i;
              we_d    = 1'b1;
              state_d = S_MEM;
            end
          end
          pop_i: begin
            if (sp_val_i == STACK_HI) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              op_d    = OP_POP;
              addr_d  = sp_val_i;
              we_d    = 1'b0;
              state_d = S_MEM;
            end
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (mem.ack) begin
          if (!we_q) dout_d = mem.rdata;
          state_d = S_UPD;
        end
      end
      S_UPD:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem.req   = (state_q == S_MEM);
  assign mem.we    = (state_q == S_MEM) && we_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;

  assign sp_ld_o  = (state_q == S_UPD) && (op_q == OP_INIT);
  assign sp_dec_o = (state_q == S_UPD) && (op_q == OP_PUSH);
  assign sp_inc_o = (state_q == S_UPD) && (op_q == OP_POP);
  assign sp_din_o = STACK_HI;

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);
  assign err_o  = (state_q == S_DONE) && err_q;
  assign dout_o = dout_q;

endmodule
